// File: rtl/idecode.sv
// RV32I instruction-decode stage: 32x32 register file plus the registered ID/EX latch.
// Define IDECODE_FORWARD_EN to bypass same-edge write-back data into the captured operands.
module idecode #(
  parameter int RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic [13:0] pc_i,
  input  logic        valid_i,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        valid_o,
  output logic [13:0] pc_o,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm_o,
  output logic [4:0]  rd_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] r_rf [0:RF_DEPTH-1];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic [31:0] w_rs1_rf;
  logic [31:0] w_rs2_rf;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm;
  logic        w_wb_live;

  assign w_opcode  = instr_i[6:0];
  assign w_rs1_idx = instr_i[19:15];
  assign w_rs2_idx = instr_i[24:20];
  assign w_wb_live = wb_en && (wb_addr != 5'd0);

  // Register file; entry 0 is never written so x0 stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wb_live) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  assign w_rs1_rf = (w_rs1_idx == 5'd0) ? 32'd0 : r_rf[w_rs1_idx];
  assign w_rs2_rf = (w_rs2_idx == 5'd0) ? 32'd0 : r_rf[w_rs2_idx];

`ifdef IDECODE_FORWARD_EN
  assign w_rs1_val = (w_wb_live && (wb_addr == w_rs1_idx)) ? wb_data : w_rs1_rf;
  assign w_rs2_val = (w_wb_live && (wb_addr == w_rs2_idx)) ? wb_data : w_rs2_rf;
`else
  assign w_rs1_val = w_rs1_rf;
  assign w_rs2_val = w_rs2_rf;
`endif

  always_comb begin
    w_imm = 32'd0;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR:
        w_imm = {{20{instr_i[31]}}, instr_i[31:20]};
      OP_STORE:
        w_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OP_BRANCH:
        w_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {instr_i[31:12], 12'h000};
      OP_JAL:
        w_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      default:
        w_imm = 32'd0;
    endcase
  end

  // ID/EX latch: flush beats stall, stall beats capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      rs1_data   <= '0;
      rs2_data   <= '0;
      imm_o      <= '0;
      rd_o       <= '0;
      opcode_o   <= '0;
      funct3_o   <= '0;
      funct7b5_o <= 1'b0;
    end else if (!stall) begin
      valid_o    <= valid_i;
      pc_o       <= pc_i;
      rs1_data   <= w_rs1_val;
      rs2_data   <= w_rs2_val;
      imm_o      <= w_imm;
      rd_o       <= instr_i[11:7];
      opcode_o   <= w_opcode;
      funct3_o   <= instr_i[14:12];
      funct7b5_o <= instr_i[30];
    end
  end

endmodule

// File: doc/idecode.md
# idecode

Instruction-decode stage sitting directly downstream of `IFetch`. It consumes the 32-bit instruction and its 14-bit address and owns the 32×32 register file. It produces register operands, a sign-extended immediate and decoded fields for the execute stage. All outputs are registered, forming the ID/EX pipeline latch, with stall and flush control.

## Interface
- `RF_DEPTH`, 32: number of architectural registers; `x0` reads as zero.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_i`  in  32  RV32I instruction from `IFetch`.
- `pc_i`  in  14  instruction address from `IFetch` (`addr_o`).
- `valid_i`  in  1  `instr_i`/`pc_i` hold a real instruction.
- `stall`  in  1  hold the ID/EX latch.
- `flush`  in  1  squash the latch contents; driven by taken branch/jump (`PCSrc`).
- `wb_en`  in  1  register-file write enable.
- `wb_addr`  in  5  write-back register index.
- `wb_data`  in  32  write-back data.
- `valid_o`  out  1  latch holds a live instruction.
- `pc_o`  out  14  latched `pc_i`.
- `rs1_data`, `rs2_data`  out  32 each  operand values.
- `imm_o`  out  32  sign-extended immediate.
- `rd_o`  out  5  destination index.
- `opcode_o`  out  7  `instr[6:0]`.
- `funct3_o`  out  3  `instr[14:12]`.
- `funct7b5_o`  out  1  `instr[30]`.

## Operation
- Register file:
  - 32 × 32-bit array, written on the rising edge when `wb_en=1` and `wb_addr≠0`.
  - Writes to `x0` are ignored; `x0` always reads 0.
  - Writes proceed regardless of `stall`/`flush`.
- Reads are combinational on `instr[19:15]` and `instr[24:20]`, and are captured into the latch.
- Immediate by opcode:
  - I-type (`0000011`, `0010011`, `1100111`): `{20{i[31]}, i[31:20]}`.
  - S-type (`0100011`): `{i[31:25], i[11:7]}` sign-extended.
  - B-type (`1100011`): `{i[31], i[7], i[30:25], i[11:8], 0}` sign-extended.
  - U-type (`0110111`, `0010111`): `{i[31:12], 12'h0}`.
  - J-type (`1101111`): `{i[31], i[19:12], i[20], i[30:21], 0}` sign-extended.
  - Any other opcode: `imm_o=0`.
- Latch update priority, highest first:
  - `flush`: `valid_o←0`; all other outputs ←0.
  - `stall`: all outputs hold.
  - Otherwise: capture decode of the current inputs; `valid_o←valid_i`.
- `valid_i=0` without flush: fields are still captured, `valid_o=0`.

## Timing
- Reset (async, immediate): all outputs 0, `valid_o=0`, all 32 registers cleared to 0.
- Release of `rst` is sampled at the next rising edge; no partial state survives reset mid-operation.
- Latency: instruction presented in cycle N appears on the outputs after edge N+1 (1 cycle).
- `stall` and `flush` both high: flush wins.
- A `wb_en` write and a latch capture at the same edge: capture sees the pre-write register value unless `FORWARD_EN` is defined.
- With `stall` high, outputs hold; operand values do not refresh from later write-backs until `stall` is released and the latch recaptures.

## Configuration
- `IDECODE_FORWARD_EN` defined:
  - Write-through bypass: if `wb_en=1`, `wb_addr≠0` and `wb_addr` equals the rs1/rs2 index, the latch captures `wb_data` for that operand.
- `IDECODE_FORWARD_EN` undefined:
  - No bypass; the old value is captured; the hazard is left to the pipeline control.

## Test plan
- Assert `rst` mid-run with `valid_o=1` -> all outputs 0 and `rs1_data` for any reg reads 0 immediately, before the next edge.
- `instr_i=0x00500093` (addi x1,x0,5), `pc_i=0x0006`, `valid_i=1` -> after one edge: `imm_o=0x00000005`, `rd_o=1`, `opcode_o=0x13`, `pc_o=0x0006`, `valid_o=1`.
- `instr_i=0xFE208CE3` (beq x1,x2,-8) -> `imm_o=0xFFFFFFF8`; `instr_i=0x123450B7` (lui) -> `imm_o=0x12345000`, `rd_o=1`.
- `wb_en=1`, `wb_addr=0`, `wb_data=0xFFFFFFFF`, then decode `0x00000113` -> `rs1_data=0`.
- `wb_en=1`, `wb_addr=1`, `wb_data=0xDEADBEEF` in the same cycle as `instr_i=0x00008113`:
  - Macro defined -> `rs1_data=0xDEADBEEF`.
  - Macro undefined -> `rs1_data=0`; re-decode next cycle -> `0xDEADBEEF`.
- Latch holds addi; `stall=1` for 2 cycles with new `instr_i` -> outputs unchanged. Then `stall=1` and `flush=1` together -> `valid_o=0`, `imm_o=0`.
